led_matrix_pwm: RTL and testbench
=================================

# led_matrix_pwm

Grayscale scan driver for multiplexed LED matrix featherwings. It holds a double-buffered framebuffer of `BPP`-bit pixels. It scans rows one at a time and modulates each column with per-pixel PWM brightness. A blanking interval before every row suppresses ghosting. The block sits between pixel-producing logic (host write port) and the matrix row/column pins, and generalises the fixed 6x6 on/off scanner in rows, columns, brightness depth and column polarity.

## Interface
- `ROWS`, 6, number of matrix rows (2..16)
- `COLS`, 6, number of matrix columns (2..16)
- `BPP`, 4, brightness bits per pixel (1..8); PWM steps per row = 2^BPP-1
- `SLOT_CYCLES`, 64, clk cycles per PWM step (>=1)
- `BLANK_CYCLES`, 8, clk cycles of blanking before each row (>=1)
- `COL_ACTIVE_LOW`, 1, 1: column lit when driven 0; 0: lit when driven 1
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `wr_en`  in  1  write strobe into back buffer
- `wr_addr`  in  $clog2(ROWS*COLS)  pixel index = r*COLS + c
- `wr_data`  in  BPP  pixel brightness, 0 = off, 2^BPP-1 = full
- `swap_req`  in  1  request back/front buffer exchange at next frame boundary
- `swap_ack`  out  1  one-cycle pulse: swap performed
- `frame_start`  out  1  one-cycle pulse: row 0 scan begins
- `row`  out  ROWS  one-hot active-high row enable; bit r = row r
- `col`  out  COLS  column drive, polarity per COL_ACTIVE_LOW

## Operation
- Two buffers of ROWS*COLS x BPP registers, selected by `front_sel`. Writes go to the back buffer; the scan reads the front buffer only.
- `wr_en` with `wr_addr >= ROWS*COLS` is ignored.
- Scan FSM per row: BLANK (`row`=0, all columns unlit, BLANK_CYCLES cycles) -> DRIVE (`row`=1<<r, (2^BPP-1)*SLOT_CYCLES cycles) -> BLANK of row r+1. After row ROWS-1, it wraps to row 0.
- DRIVE step s (0..2^BPP-2, each SLOT_CYCLES long): column c is lit iff pixel(r,c) > s. Value v is therefore lit for v*SLOT_CYCLES cycles per row, starting at the first DRIVE cycle.
- `swap_req` sets a sticky `swap_pending`. Further requests while pending have no additional effect.
- Frame boundary: the transition from the last DRIVE cycle of row ROWS-1 to BLANK of row 0.
  - If `swap_pending` is set at the boundary: toggle `front_sel`, clear pending, pulse `swap_ack`.
  - A `swap_req` arriving in the boundary cycle itself is honoured, and acknowledged at that boundary.
- A write in the same cycle as a swap lands in the buffer that was back during that cycle, which becomes front.

## Timing
- Reset (asynchronous, `rst_n`=0) sets:
  - outputs: `row`=0; `col` all unlit (all 1 if COL_ACTIVE_LOW, else all 0); `swap_ack`=0; `frame_start`=0
  - state: both buffers 0; `front_sel`=0; `swap_pending`=0; FSM = BLANK, row 0, counters 0
- Outputs are registers. Each output reflects the phase of the cycle it appears in: the first BLANK cycle already shows `row`=0, and the first DRIVE cycle already shows the lit row.
- Row period = BLANK_CYCLES + (2^BPP-1)*SLOT_CYCLES. Frame period = ROWS * row period.
- `frame_start` pulses in the first BLANK cycle of row 0 after a wrap. It does not pulse after reset release.
- `swap_ack` pulses coincident with `frame_start`. The new front buffer is displayed from that frame's row 0 DRIVE onward.
- Write-to-display latency: 1 cycle into the back buffer; visible only after the following swap.
- Reset asserted mid-frame blanks the outputs immediately (asynchronous). The scan restarts from row 0 BLANK after release.

## Test plan
Bench parameters: ROWS=6, COLS=6, BPP=4, SLOT_CYCLES=4, BLANK_CYCLES=2, COL_ACTIVE_LOW=1. Row period 62 cycles; frame 372 cycles.
- Reset: hold `rst_n`=0 -> `row`=0, `col`=6'b111111. Release -> 2 cycles `row`=0, then `row`=6'b000001 for 60 cycles, all columns unlit.
- Write addr 0 = 15 and addr 5 = 1, then pulse `swap_req` -> `swap_ack` with the next `frame_start`. In row 0 DRIVE, `col[0]`=0 for all 60 cycles and `col[5]`=0 for the first 4 cycles only.
- Write addr 7 = 8 and swap -> during row 1 DRIVE, `col[1]`=0 for exactly 32 cycles then 1 for 28 cycles. All other pixels stay unlit.
- Writes without `swap_req` -> display unchanged across 3 frames. Two `swap_req` pulses within one frame -> exactly one `swap_ack`. A `swap_req` in the boundary cycle -> acknowledged at that boundary.
- Write addr 36 = 15 (out of range) -> no effect. Write addr 35 = 15 and swap -> `row[5]` DRIVE has `col[5]`=0 for 60 cycles.
- Assert `rst_n` during row 3 DRIVE -> same cycle `row`=0 and `col` all 1. After release, previously written pixels are dark and the scan restarts at row 0 BLANK.

Source files
------------

// File: rtl/led_matrix_pwm.sv
// Multiplexed LED matrix scan driver: double-buffered BPP-bit framebuffer,
// one row lit at a time with per-pixel PWM and a blanking gap before each row.
module led_matrix_pwm #(
    parameter int ROWS           = 6,
    parameter int COLS           = 6,
    parameter int BPP            = 4,
    parameter int SLOT_CYCLES    = 64,
    parameter int BLANK_CYCLES   = 8,
    parameter int COL_ACTIVE_LOW = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wr_en,
    input  logic [$clog2(ROWS*COLS)-1:0]    wr_addr,
    input  logic [BPP-1:0]                  wr_data,
    input  logic                            swap_req,
    output logic                            swap_ack,
    output logic                            frame_start,
    output logic [ROWS-1:0]                 row,
    output logic [COLS-1:0]                 col
);

    localparam int NPIX  = ROWS * COLS;
    localparam int AW    = $clog2(NPIX);
    localparam int RW    = $clog2(ROWS);
    localparam int STEPS = (1 << BPP) - 1;
    localparam int MAXC  = (SLOT_CYCLES > BLANK_CYCLES) ? SLOT_CYCLES : BLANK_CYCLES;
    localparam int CW    = $clog2(MAXC + 1);

    localparam logic [CW-1:0]   BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0]   SLOT_LAST  = CW'(SLOT_CYCLES - 1);
    localparam logic [BPP-1:0]  STEP_LAST  = BPP'(STEPS - 1);
    localparam logic [RW-1:0]   ROW_LAST   = RW'(ROWS - 1);
    localparam logic [ROWS-1:0] ROW_ONE    = ROWS'(1);
    localparam logic [COLS-1:0] COL_OFF    = (COL_ACTIVE_LOW != 0) ? {COLS{1'b1}} : {COLS{1'b0}};

    typedef enum logic {BLANK, DRIVE} phase_t;

    phase_t          phase_q, phase_d;
    logic [RW-1:0]   row_idx_q, row_idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BPP-1:0]  step_q, step_d;
    logic            boundary;
    logic            front_sel;
    logic            swap_pending;
    logic            swap_now;
    logic            wr_ok;
    logic [ROWS-1:0] row_nx;
    logic [COLS-1:0] col_nx;
    logic [AW-1:0]   pix_idx;
    logic [BPP-1:0]  pix;
    logic            lit;

    logic [BPP-1:0]  buf0 [NPIX];
    logic [BPP-1:0]  buf1 [NPIX];

    // Scan sequencer: BLANK counts cycles, DRIVE counts cycles within a slot and slots within a row.
    always_comb begin
        phase_d   = phase_q;
        row_idx_d = row_idx_q;
        cnt_d     = cnt_q + 1'b1;
        step_d    = step_q;
        boundary  = 1'b0;
        case (phase_q)
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    phase_d = DRIVE;
                    cnt_d   = '0;
                    step_d  = '0;
                end
            end
            DRIVE: begin
                if (cnt_q == SLOT_LAST) begin
                    cnt_d = '0;
                    if (step_q == STEP_LAST) begin
                        phase_d = BLANK;
                        step_d  = '0;
                        if (row_idx_q == ROW_LAST) begin
                            row_idx_d = '0;
                            boundary  = 1'b1;
                        end else begin
                            row_idx_d = row_idx_q + 1'b1;
                        end
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Outputs are computed from the next state so they line up with the phase they belong to.
    always_comb begin
        swap_now = boundary && (swap_pending || swap_req);
        wr_ok    = wr_en && ({1'b0, wr_addr} < (AW+1)'(NPIX));
        row_nx   = (phase_d == DRIVE) ? (ROW_ONE << row_idx_d) : '0;
        col_nx   = COL_OFF;
        pix_idx  = '0;
        pix      = '0;
        lit      = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            pix_idx   = AW'(int'(row_idx_d) * COLS + c);
            pix       = front_sel ? buf1[pix_idx] : buf0[pix_idx];
            lit       = (phase_d == DRIVE) && (pix > step_d);
            col_nx[c] = (COL_ACTIVE_LOW != 0) ? ~lit : lit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= BLANK;
            row_idx_q    <= '0;
            cnt_q        <= '0;
            step_q       <= '0;
            front_sel    <= 1'b0;
            swap_pending <= 1'b0;
            swap_ack     <= 1'b0;
            frame_start  <= 1'b0;
            row          <= '0;
            col          <= COL_OFF;
        end else begin
            phase_q      <= phase_d;
            row_idx_q    <= row_idx_d;
            cnt_q        <= cnt_d;
            step_q       <= step_d;
            front_sel    <= front_sel ^ swap_now;
            swap_pending <= boundary ? 1'b0 : (swap_pending | swap_req);
            swap_ack     <= swap_now;
            frame_start  <= boundary;
            row          <= row_nx;
            col          <= col_nx;
        end
    end

    // A write coinciding with a swap targets the current back buffer, which then becomes front.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPIX; i++) begin
                buf0[i] <= '0;
                buf1[i] <= '0;
            end
        end else if (wr_ok) begin
            if (front_sel)
                buf0[wr_addr] <= wr_data;
            else
                buf1[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_led_matrix_pwm.sv
// Directed bench for led_matrix_pwm: frame-by-frame scan checks against a
// two-buffer model of the framebuffer.
module tb_led_matrix_pwm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [5:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic       swap_req = 1'b0;
    logic       swap_ack;
    logic       frame_start;
    logic [5:0] row;
    logic [5:0] col;

    int n_chk  = 0;
    int n_fail = 0;

    logic [3:0] mf [36];
    logic [3:0] mb [36];

    led_matrix_pwm #(
        .ROWS(6), .COLS(6), .BPP(4), .SLOT_CYCLES(4), .BLANK_CYCLES(2), .COL_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .swap_req(swap_req), .swap_ack(swap_ack), .frame_start(frame_start),
        .row(row), .col(col)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 36; i++) begin
            mf[i] = '0;
            mb[i] = '0;
        end
    endtask

    task automatic model_swap();
        logic [3:0] t;
        for (int i = 0; i < 36; i++) begin
            t     = mf[i];
            mf[i] = mb[i];
            mb[i] = t;
        end
    endtask

    task automatic wr(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = 6'(a);
        wr_data = 4'(d);
        @(negedge clk);
        wr_en = 1'b0;
        if (a < 36) mb[a] = 4'(d);
    endtask

    task automatic pulse_swap();
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Entered at the first BLANK cycle of row r; leaves at the first BLANK cycle of the next row.
    task automatic check_row(input int r, input logic fs_exp, input logic ack_exp);
        int err;
        logic [5:0] erow, ecol;
        err = 0;
        for (int k = 0; k < 62; k++) begin
            if (k < 2) begin
                erow = '0;
                ecol = 6'h3F;
            end else begin
                erow = 6'(1) << r;
                for (int c = 0; c < 6; c++)
                    ecol[c] = !((k - 2) < mf[r*6 + c] * 4);
            end
            if (row !== erow || col !== ecol) err++;
            if (k == 0 && r == 0) begin
                chk("frame_start", frame_start, fs_exp);
                chk("swap_ack", swap_ack, ack_exp);
            end else if (frame_start !== 1'b0 || swap_ack !== 1'b0) begin
                err++;
            end
            @(negedge clk);
        end
        chk($sformatf("row%0d_scan_errors", r), err, 0);
    endtask

    task automatic check_frame(input logic fs_exp, input logic ack_exp);
        for (int r = 0; r < 6; r++)
            check_row(r, fs_exp, ack_exp);
    endtask

    task automatic wait_frame(output logic ack);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("frame_start_seen", seen, 1);
        ack = swap_ack;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic ack;
        model_reset();

        // reset state
        #12;
        chk("rst_row", row, 0);
        chk("rst_col", col, 6'h3F);
        chk("rst_ack", swap_ack, 0);
        chk("rst_fs", frame_start, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check_frame(1'b0, 1'b0);

        // pixels 0 and 5, then swap
        wr(0, 15);
        wr(5, 1);
        pulse_swap();
        wait_frame(ack);
        chk("swap1_ack", ack, 1);
        model_swap();
        check_frame(1'b1, 1'b1);

        // half brightness on row 1 col 1
        wr(7, 8);
        pulse_swap();
        wait_frame(ack);
        chk("swap2_ack", ack, 1);
        model_swap();
        check_frame(1'b1, 1'b1);

        // writes without swap leave the display unchanged
        wr(14, 15);
        wr(20, 9);
        wait_frame(ack);
        chk("noswap_ack", ack, 0);
        for (int f = 0; f < 3; f++)
            check_frame(1'b1, 1'b0);

        // two requests in one frame give one ack
        pulse_swap();
        cycles(10);
        pulse_swap();
        wait_frame(ack);
        chk("dbl_ack", ack, 1);
        model_swap();
        check_frame(1'b1, 1'b1);
        check_frame(1'b1, 1'b0);

        // request in the boundary cycle itself
        wr(30, 7);
        cycles(370);
        chk("pre_boundary_row", row, 6'b100000);
        pulse_swap();
        model_swap();
        check_frame(1'b1, 1'b1);
        check_frame(1'b1, 1'b0);

        // out-of-range write ignored, last pixel written
        wr(36, 15);
        wr(35, 15);
        pulse_swap();
        wait_frame(ack);
        chk("swap5_ack", ack, 1);
        model_swap();
        check_frame(1'b1, 1'b1);

        // asynchronous reset during row 3 DRIVE
        cycles(200);
        chk("pre_reset_row", row, 6'b001000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_row", row, 0);
        chk("async_rst_col", col, 6'h3F);
        chk("async_rst_ack", swap_ack, 0);
        model_reset();
        @(negedge clk);
        cycles(2);
        rst_n = 1'b1;
        check_frame(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
